// File: rtl/logic_unit_sequencer_if.sv
// Handshake/operand bundle between ALU control decode and the logic sequencer.
// The zero output exists only when LOGIC_SEQ_ZERO_FLAG_EN is defined.
interface logic_unit_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic             zero;

    modport master (output start, op, A, B, input ready, busy, done, R, zero);
    modport slave  (input start, op, A, B, output ready, busy, done, R, zero);
`else
    modport master (output start, op, A, B, input ready, busy, done, R);
    modport slave  (input start, op, A, B, output ready, busy, done, R);
`endif
endinterface

// File: rtl/logic_unit_sequencer.sv
// Slice-serial bitwise logic unit: one shared SLICE-bit AND/OR/XOR/NOR cell swept over WIDTH bits.
// Optional zero flag enabled by defining LOGIC_SEQ_ZERO_FLAG_EN.
module logic_unit_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    logic_unit_sequencer_if.slave   bus
);
    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] r_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic [SLICE-1:0] acc_q;
    logic             zero_q;
`endif

    logic [SLICE-1:0] a_slices [N];
    logic [SLICE-1:0] b_slices [N];
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] cell_d;
    logic             last_slice;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign a_slices[gi] = a_q[gi*SLICE +: SLICE];
            assign b_slices[gi] = b_q[gi*SLICE +: SLICE];
        end
    endgenerate

    assign a_sl       = a_slices[cnt_q];
    assign b_sl       = b_slices[cnt_q];
    assign last_slice = (cnt_q == CNT_W'(N - 1));

    // The single shared logic cell; slices are independent, so no carry path.
    always_comb begin
        cell_d = '0;
        case (op_q)
            2'b00:   cell_d = a_sl & b_sl;
            2'b01:   cell_d = a_sl | b_sl;
            2'b10:   cell_d = a_sl ^ b_sl;
            default: cell_d = ~(a_sl | b_sl);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            r_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            acc_q   <= '0;
            zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        op_q    <= bus.op;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                        acc_q   <= '0;
`endif
                    end
                end
                RUN: begin
                    r_q[SLICE*cnt_q +: SLICE] <= cell_d;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                    acc_q <= acc_q | cell_d;
`endif
                    if (last_slice) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                        // Fold in the final slice here since acc_q has not absorbed it yet.
                        zero_q  <= ~|(acc_q | cell_d);
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.R     = r_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    assign bus.zero  = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Self-checking bench for logic_unit_sequencer: vector table plus handshake corner sequences,
// with expected results queued at accept time and checked on each done pulse.
module tb_logic_unit_sequencer;
    localparam int WIDTH = 32;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_sequencer_if #(.WIDTH(WIDTH)) bus_if ();

    logic_unit_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic zero_obs;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    assign zero_obs = bus_if.zero;
`else
    assign zero_obs = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   tests     = 0;
    int   fails     = 0;
    int   done_seen = 0;
    int   busy_seen = 0;
    int   cyc_no    = 0;
    int   acc_cyc[4];
    int   n_acc;

    function automatic logic [31:0] ref_logic(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge and score any done pulse.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        cyc_no++;
        if (bus_if.busy) busy_seen++;
        if (bus_if.done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("[TB] done R=%h expR=%h zero=%0b expZero=%0b", bus_if.R, e.r, zero_obs, e.z);
                check("R_at_done", bus_if.R, e.r);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                check("zero_at_done", {31'd0, zero_obs}, {31'd0, e.z});
`endif
            end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !bus_if.ready; i++) cyc();
        check("ready_wait", {31'd0, bus_if.ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        wait_ready();
        bus_if.op    = v.op;
        bus_if.A     = v.a;
        bus_if.B     = v.b;
        bus_if.start = 1'b1;
        e.r = v.r;
        e.z = v.z;
        sb_q.push_back(e);
        busy_seen = 0;
        done_seen = 0;
        cyc();
        bus_if.start = 1'b0;
        bus_if.A     = $urandom;
        bus_if.B     = $urandom;
        bus_if.op    = 2'($urandom_range(0, 3));
        for (int i = 0; i < N + 4 && done_seen == 0; i++) cyc();
        check("done_count", done_seen, 1);
        check("busy_cycles", busy_seen, N);
        cyc();
        check("ready_after_done", {31'd0, bus_if.ready}, 32'd1);
        check("done_one_cycle", {31'd0, bus_if.done}, 32'd0);
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0};
        vecs[1] = '{2'b01, 32'h12345678, 32'h87654321, 32'h97755779, 1'b0};
        vecs[2] = '{2'b10, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0};
        vecs[3] = '{2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[4] = '{2'b00, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1};
        vecs[5] = '{2'b00, 32'h00000001, 32'h00000001, 32'h00000001, 1'b0};

        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.A     = '0;
        bus_if.B     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_R", bus_if.R, 32'd0);
        check("rst_done", {31'd0, bus_if.done}, 32'd0);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_ready", {31'd0, bus_if.ready}, 32'd1);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        check("rst_zero", {31'd0, zero_obs}, 32'd0);
`endif
        rst_n = 1'b1;
        cyc();

        // Vector table
        for (int k = 0; k < 6; k++) begin
            $display("[TB] vector %0d op=%0d A=%h B=%h", k, vecs[k].op, vecs[k].a, vecs[k].b);
            run_vec(vecs[k]);
        end

        // start re-asserted during RUN and DONE must be ignored
        wait_ready();
        bus_if.op    = 2'b01;
        bus_if.A     = 32'h12345678;
        bus_if.B     = 32'h87654321;
        bus_if.start = 1'b1;
        e.r = 32'h97755779;
        e.z = 1'b0;
        sb_q.push_back(e);
        done_seen = 0;
        cyc();
        bus_if.start = 1'b0;
        cyc();
        cyc();
        bus_if.start = 1'b1;
        bus_if.op    = 2'b00;
        bus_if.A     = 32'd0;
        bus_if.B     = 32'd0;
        for (int i = 0; i < N + 4 && done_seen == 0; i++) cyc();
        cyc();
        bus_if.start = 1'b0;
        for (int i = 0; i < N + 2; i++) cyc();
        $display("[TB] protection sequence done_count=%0d", done_seen);
        check("protect_done_count", done_seen, 1);
        check("protect_ready", {31'd0, bus_if.ready}, 32'd1);
        check("protect_sb_empty", sb_q.size(), 0);

        // Back-to-back with start held high
        wait_ready();
        n_acc     = 0;
        done_seen = 0;
        for (int i = 0; i < 6 * (N + 2) + 10 && done_seen < 4; i++) begin
            if (bus_if.ready && n_acc < 4) begin
                bus_if.op    = 2'($urandom_range(0, 3));
                bus_if.A     = $urandom;
                bus_if.B     = $urandom;
                bus_if.start = 1'b1;
                e.r = ref_logic(bus_if.op, bus_if.A, bus_if.B);
                e.z = (e.r == 32'd0);
                sb_q.push_back(e);
                acc_cyc[n_acc] = cyc_no;
                n_acc++;
                $display("[TB] b2b accept %0d op=%0d A=%h B=%h", n_acc, bus_if.op, bus_if.A, bus_if.B);
            end else begin
                bus_if.op    = 2'($urandom_range(0, 3));
                bus_if.A     = $urandom;
                bus_if.B     = $urandom;
                bus_if.start = (n_acc < 4);
            end
            cyc();
        end
        bus_if.start = 1'b0;
        check("b2b_accepts", n_acc, 4);
        check("b2b_done_count", done_seen, 4);
        check("b2b_sb_empty", sb_q.size(), 0);
        for (int k = 1; k < 4; k++) check("b2b_spacing", acc_cyc[k] - acc_cyc[k-1], N + 2);

        // Reset abort mid-operation
        wait_ready();
        bus_if.op    = 2'b10;
        bus_if.A     = 32'hFFFFFFFF;
        bus_if.B     = 32'h12345678;
        bus_if.start = 1'b1;
        done_seen    = 0;
        cyc();
        bus_if.start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("abort_partial_R", {16'd0, bus_if.R[15:0]}, 32'h0000A987);
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] reset abort applied R=%h", bus_if.R);
        check("abort_R", bus_if.R, 32'd0);
        check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort_ready", {31'd0, bus_if.ready}, 32'd1);
        check("abort_done", {31'd0, bus_if.done}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) cyc();
        check("abort_no_done", done_seen, 0);
        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/logic_unit_sequencer.md
Name: logic_unit_sequencer

Overview:
- Multi-cycle sequencer for the bitwise-logic path of the mini MIPS ALU.
- Holds one shared SLICE-bit logic cell (AND/OR/XOR/NOR) and drives it over all slices of a WIDTH-bit operand pair, one slice per clock.
- Latches operands on a start/ready handshake, writes each result slice into an output register, and pulses done when the full word is complete.
- Sits between the ALU control decode and the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, width of the shared logic cell processed per cycle.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; accepted only when ready=1.
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
- A  input  WIDTH  operand A; sampled on the accept edge.
- B  input  WIDTH  operand B; sampled on the accept edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle completion pulse.
- R  output  WIDTH  result register.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, slice counter=0, operand/op latches=0, R=0, done=0, busy=0, ready=1.
- Reset mid-operation aborts immediately. No done pulse. R returns to 0.
- States are IDLE, RUN and DONE. N = WIDTH/SLICE (8 at default).
- IDLE: ready=1. start=1 at an edge is the accept edge. On that edge:
  - latch A, B and op;
  - set counter=0;
  - go to RUN.
  - R keeps its previous value.
- RUN: busy=1, ready=0. Each edge:
  - R[cnt*SLICE +: SLICE] <= f(op, A_lat slice, B_lat slice);
  - cnt increments.
  - On the edge that writes slice N-1: go to DONE and set cnt=0.
- DONE: done=1 for exactly one cycle, ready=0. Next edge returns to IDLE.
- Timing: accept at edge 0; slices written at edges 1..N; done high between edges N and N+1; ready high again after edge N+1.
- start while not in IDLE is ignored. There is no queuing, and latched operands are unaffected.
- A, B and op may change freely after the accept edge.
- R in RUN is partially updated and must not be consumed. R is valid from the done cycle until the next accept edge.
- Back-to-back: start held high in the ready cycle after DONE is accepted on that edge.
- The NOR slice is the bitwise inverse of the OR slice. No carries and no inter-slice dependence.

Optional Feature:
- Macro: LOGIC_SEQ_ZERO_FLAG_EN.
- Defined:
  - Adds output zero (1 bit, reset 0).
  - Internal accumulator is cleared on the accept edge and ORed with each written slice during RUN.
  - zero = ~accumulator, registered on the edge entering DONE.
  - zero is valid with done and held until the next accept edge.
- Undefined: no zero port and no accumulator logic.

Test Plan:
- Reset checks: rst_n low -> R=0, done=0, busy=0, ready=1. Release, then op=00, A=FFFF0000, B=0F0F0F0F, start one cycle -> busy for 8 cycles, done pulse 1 cycle, R=0F0F0000.
- OR/XOR/NOR results:
  - op=01, A=12345678, B=87654321 -> R=97755779.
  - op=10, A=A5A5A5A5, B=FFFFFFFF -> R=5A5A5A5A.
  - op=11, A=0, B=0 -> R=FFFFFFFF.
- Busy/DONE protection: start re-asserted with A=0, B=0 during RUN cycle 3 and during DONE -> ignored; R equals result of the original operands; exactly one done.
- Back-to-back: start held high continuously with changing operands -> accepts every N+2 cycles; each done coincides with the correct R; no lost or duplicated results.
- Reset abort: rst_n pulsed low after slice 3 written -> immediate IDLE, R=0, no done. Next operation completes correctly.
- With LOGIC_SEQ_ZERO_FLAG_EN:
  - op=00, A=AAAAAAAA, B=55555555 -> R=0, zero=1 at done.
  - op=00, A=00000001, B=00000001 -> zero=0.
